// File: rtl/arb_mux16.sv
// -----------------------------------------------------------------------------
// arb_mux16
//
// Two-requester arbiter in front of a single-word output register. Each cycle
// the output register may take a new word ("load") when it is empty or when
// its held word is being consumed downstream. Ties between A and B are broken
// round-robin (FIXED_PRIORITY = 0) or always in favour of A (FIXED_PRIORITY = 1).
//
// Parameters
//   FIXED_PRIORITY : 0 = round-robin tie-break, 1 = A always wins ties
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   reqA      in   A has a valid word on inA
//   inA       in   [15:0] A data
//   ackA      out  A's word is captured at this edge
//   reqB      in   B has a valid word on inB
//   inB       in   [15:0] B data
//   ackB      out  B's word is captured at this edge
//   out       out  [15:0] registered selected word
//   outValid  out  out holds an unconsumed word
//   outReady  in   downstream accepts out at this edge
//   select    out  source of the held word: 0 = A, 1 = B
// -----------------------------------------------------------------------------
module arb_mux16 #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqA,
    input  logic [15:0] inA,
    output logic        ackA,
    input  logic        reqB,
    input  logic [15:0] inB,
    output logic        ackB,
    output logic [15:0] out,
    output logic        outValid,
    input  logic        outReady,
    output logic        select
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL_A = 2'd1,
        FULL_B = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        last_served;      // 0 = A served last, 1 = B served last
    logic        last_served_nxt;
    logic [15:0] out_nxt;
    logic        select_nxt;
    logic        load;
    logic        win_valid;
    logic        win_b;            // winner identity when win_valid: 0 = A, 1 = B

    assign outValid = (state != EMPTY);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case/if chain can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt       = state;
        last_served_nxt = last_served;
        out_nxt         = out;
        select_nxt      = select;
        win_valid       = 1'b0;
        win_b           = 1'b0;
        ackA            = 1'b0;
        ackB            = 1'b0;

        load = (state == EMPTY) || (outValid && outReady);

        unique case ({reqA, reqB})
            2'b10: begin
                win_valid = 1'b1;
                win_b     = 1'b0;
            end
            2'b01: begin
                win_valid = 1'b1;
                win_b     = 1'b1;
            end
            2'b11: begin
                win_valid = 1'b1;
                // Round-robin grants whoever was not served last.
                win_b     = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_served;
            end
            default: begin
                win_valid = 1'b0;
            end
        endcase

        if (load) begin
            if (win_valid) begin
                state_nxt       = win_b ? FULL_B : FULL_A;
                out_nxt         = win_b ? inB : inA;
                select_nxt      = win_b;
                last_served_nxt = win_b;
            end else begin
                // out and select deliberately keep their last values.
                state_nxt = EMPTY;
            end
        end

        // Acks are qualified by rst_n so none is issued while reset is held,
        // even though the register reads EMPTY and would otherwise load.
        ackA = rst_n && load && win_valid && !win_b;
        ackB = rst_n && load && win_valid &&  win_b;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            out         <= 16'h0000;
            select      <= 1'b0;
            last_served <= 1'b1;   // B served "last" so the first tie goes to A
        end else begin
            state       <= state_nxt;
            out         <= out_nxt;
            select      <= select_nxt;
            last_served <= last_served_nxt;
        end
    end

endmodule

// File: tb/tb_arb_mux16.sv
// -----------------------------------------------------------------------------
// tb_arb_mux16
//
// Drives two arb_mux16 instances (round-robin and fixed-priority) with shared
// stimulus and compares both against a transaction-level reference model:
// per instance it tracks whether a word is held, its value and source, and who
// was served last. Directed sequences cover reset, single requester, ties,
// backpressure, fixed priority and drain; a randomized run follows.
// -----------------------------------------------------------------------------
module tb_arb_mux16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reqA, reqB, outReady;
    logic [15:0] inA, inB;

    logic        ack_a0, ack_b0, valid0, sel0;
    logic [15:0] out0;
    logic        ack_a1, ack_b1, valid1, sel1;
    logic [15:0] out1;

    int checks = 0;
    int errors = 0;

    // Reference model, index 0 = round-robin instance, 1 = fixed priority.
    bit          m_valid  [2];
    logic [15:0] m_out    [2];
    bit          m_sel    [2];
    bit          m_last_b [2];

    arb_mux16 #(.FIXED_PRIORITY(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .reqA(reqA), .inA(inA), .ackA(ack_a0),
        .reqB(reqB), .inB(inB), .ackB(ack_b0),
        .out(out0), .outValid(valid0), .outReady(outReady), .select(sel0)
    );

    arb_mux16 #(.FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .reqA(reqA), .inA(inA), .ackA(ack_a1),
        .reqB(reqB), .inB(inB), .ackB(ack_b1),
        .out(out1), .outValid(valid1), .outReady(outReady), .select(sel1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i]  = 1'b0;
            m_out[i]    = 16'h0000;
            m_sel[i]    = 1'b0;
            m_last_b[i] = 1'b1;
        end
    endfunction

    function automatic logic [19:0] dut_obs(input int i);
        // {ackA, ackB, outValid, select, out}
        if (i == 0) return {ack_a0, ack_b0, valid0, sel0, out0};
        else        return {ack_a1, ack_b1, valid1, sel1, out1};
    endfunction

    // One clock cycle: apply inputs, check acks and held state before the edge,
    // then advance the model across the edge. Called at posedge+1.
    task automatic step(input string tag, input bit ra, input logic [15:0] a,
                        input bit rb, input logic [15:0] b, input bit rdy);
        int  grant [2];   // -1 none, 0 A, 1 B
        bit  can   [2];
        logic [19:0] obs;
        reqA = ra; inA = a; reqB = rb; inB = b; outReady = rdy;
        #2;
        for (int i = 0; i < 2; i++) begin
            can[i] = !m_valid[i] || rdy;
            if (ra && rb)  grant[i] = (i == 1) ? 0 : (m_last_b[i] ? 0 : 1);
            else if (ra)   grant[i] = 0;
            else if (rb)   grant[i] = 1;
            else           grant[i] = -1;
            obs = dut_obs(i);
            check($sformatf("%s/d%0d/ackA", tag, i), 32'(obs[19]),
                  32'(rst_n && can[i] && grant[i] == 0));
            check($sformatf("%s/d%0d/ackB", tag, i), 32'(obs[18]),
                  32'(rst_n && can[i] && grant[i] == 1));
            check($sformatf("%s/d%0d/outValid", tag, i), 32'(obs[17]), 32'(m_valid[i]));
            check($sformatf("%s/d%0d/select", tag, i), 32'(obs[16]), 32'(m_sel[i]));
            check($sformatf("%s/d%0d/out", tag, i), 32'(obs[15:0]), 32'(m_out[i]));
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (can[i]) begin
                    if (grant[i] >= 0) begin
                        m_valid[i]  = 1'b1;
                        m_out[i]    = (grant[i] == 1) ? b : a;
                        m_sel[i]    = (grant[i] == 1);
                        m_last_b[i] = (grant[i] == 1);
                    end else begin
                        m_valid[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    // Asynchronous reset in mid-cycle: outputs must clear without a clock edge,
    // even with both requests and outReady high.
    task automatic do_reset(input string tag);
        logic [19:0] obs;
        reqA = 1'b1; reqB = 1'b1; outReady = 1'b1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            obs = dut_obs(i);
            check($sformatf("%s/d%0d/rst_state", tag, i), 32'(obs), 32'h0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; reqA = 1'b0; reqB = 1'b0; outReady = 1'b0;
        inA = 16'h0; inB = 16'h0;
        model_reset();
        #1;
        // Reset held across edges with activity on the inputs.
        step("rst_hold0", 1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1);
        step("rst_hold1", 1'b1, 16'h3333, 1'b0, 16'h4444, 1'b0);
        rst_n = 1'b1;

        // Single requester A.
        step("single", 1'b1, 16'h9876, 1'b0, 16'h0000, 1'b1);
        check("single/out", 32'(out0), 32'h9876);
        check("single/valid", 32'(valid0), 32'h1);
        check("single/select", 32'(sel0), 32'h0);

        // Ties after reset: round-robin alternates starting with A.
        do_reset("rst_tie");
        step("tie0", 1'b1, 16'hAAAA, 1'b1, 16'h5555, 1'b1);
        check("tie0/out", 32'(out0), 32'hAAAA);
        step("tie1", 1'b1, 16'hAAAA, 1'b1, 16'h5555, 1'b1);
        check("tie1/out", 32'(out0), 32'h5555);
        check("tie1/select", 32'(sel0), 32'h1);
        check("tie1/fp_select", 32'(sel1), 32'h0);
        step("tie2", 1'b1, 16'hAAAA, 1'b1, 16'h5555, 1'b1);
        check("tie2/out", 32'(out0), 32'hAAAA);
        step("tie3", 1'b1, 16'hAAAA, 1'b1, 16'h5555, 1'b1);
        check("tie3/out", 32'(out0), 32'h5555);

        // Backpressure with B's word held.
        step("bp_load", 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("bp_hold%0d", k), 1'b1, 16'h4321, 1'b0, 16'h0000, 1'b0);
            check($sformatf("bp_hold%0d/out", k), 32'(out0), 32'h1234);
        end
        step("bp_release", 1'b1, 16'h4321, 1'b0, 16'h0000, 1'b1);
        check("bp_release/out", 32'(out0), 32'h4321);
        check("bp_release/select", 32'(sel0), 32'h0);

        // Drain: no requests, word consumed, register empties.
        step("drain", 1'b0, 16'hFFFF, 1'b0, 16'hEEEE, 1'b1);
        check("drain/valid", 32'(valid0), 32'h0);
        check("drain/out", 32'(out0), 32'h4321);
        // outReady is ignored while empty.
        step("empty_rdy", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);

        // Reset with a word held.
        step("fill", 1'b1, 16'hBEEF, 1'b0, 16'h0000, 1'b0);
        check("fill/valid", 32'(valid0), 32'h1);
        do_reset("rst_mid");

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rnd_rst");
            end else begin
                step("rnd",
                     $urandom_range(0, 9) < 6, 16'($urandom),
                     $urandom_range(0, 9) < 6, 16'($urandom),
                     $urandom_range(0, 9) < 7);
            end
        end
        step("final", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_mux16.md
ARB_MUX16 -- requirements
Module: arb_mux16

Interface
REQ-001 SHALL have parameter FIXED_PRIORITY, default 0, meaning 0 = round-robin tie-break and 1 = requester A always wins ties.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port reqA, input, 1, requester A has a valid word on inA.
REQ-005 SHALL have port inA, input, 16, requester A data.
REQ-006 SHALL have port ackA, output, 1, A's word is captured at this edge.
REQ-007 SHALL have port reqB, input, 1, requester B has a valid word on inB.
REQ-008 SHALL have port inB, input, 16, requester B data.
REQ-009 SHALL have port ackB, output, 1, B's word is captured at this edge.
REQ-010 SHALL have port out, output, 16, registered selected word.
REQ-011 SHALL have port outValid, output, 1, out holds an unconsumed word.
REQ-012 SHALL have port outReady, input, 1, downstream accepts out at this edge.
REQ-013 SHALL have port select, output, 1, source of the held word: 0 = A, 1 = B.

Function
REQ-014 SHALL implement three states: EMPTY (no word held), FULL_A (A's word held), FULL_B (B's word held); outValid = 1 exactly in FULL_A/FULL_B.
REQ-015 SHALL define load = (state == EMPTY) OR (outValid AND outReady), evaluated combinationally each cycle.
REQ-016 SHALL choose the winner combinationally: only reqA -> A; only reqB -> B; both -> per REQ-017; neither -> no winner.
REQ-017 SHALL, on reqA AND reqB with FIXED_PRIORITY = 0, grant the requester not served last (lastServed register); with FIXED_PRIORITY = 1, grant A.
REQ-018 SHALL, when load and a winner exists, capture the winner's data through the 16-bit 2:1 mux into out at the edge, set select to the winner, enter FULL_A/FULL_B, and update lastServed to the winner.
REQ-019 SHALL assert ackX combinationally, for at most one requester, exactly when load and X is the winner; ackA and ackB never both 1.
REQ-020 SHALL, when load and no winner, enter EMPTY at the edge with outValid = 0; out and select retain their last values.
REQ-021 SHALL hold out, select and state unchanged while outValid = 1 and outReady = 0, regardless of requests; no ack asserted.
REQ-022 SHALL ignore outReady while outValid = 0.
REQ-023 SHALL achieve latency of one edge: a word acked at edge n appears on out with outValid = 1 after edge n.
REQ-024 SHALL sustain one word per cycle when outReady is held 1 and requests are continuous (accept and reload at the same edge).
REQ-025 SHALL, with both requesters continuously asserting and outReady = 1 under round-robin, alternate grants A, B, A, B, ...; no requester waits more than one grant.
REQ-026 SHALL treat reqX deasserted without ackX as a withdrawn request; no state change results.

Reset
REQ-027 SHALL, while rst_n = 0, immediately force state = EMPTY, outValid = 0, out = 16'h0000, select = 0, lastServed = B, and hold ackA = ackB = 0.
REQ-028 SHALL, on reset asserted mid-operation, discard any held word; no ack is issued for it; first tie after reset is granted to A.
REQ-029 SHALL, after rst_n rises, begin arbitration at the next rising edge of clk.

Verification
REQ-030 Reset: rst_n = 0 mid-transfer with outValid = 1 -> out = 0000, outValid = 0, select = 0, ackA = ackB = 0 without a clock edge.
REQ-031 Single requester: reqA = 1, inA = 9876, outReady = 1 -> ackA = 1 that cycle, next cycle out = 9876, outValid = 1, select = 0.
REQ-032 Tie round-robin: reqA = reqB = 1, inA = AAAA, inB = 5555, outReady = 1 for 4 cycles after reset -> out sequence AAAA, 5555, AAAA, 5555; select 0, 1, 0, 1.
REQ-033 Backpressure: word 1234 held from B, outReady = 0 for 3 cycles with reqA = 1 -> out stays 1234, select = 1, ackA = 0; outReady = 1 -> ackA = 1 same cycle, next out = inA.
REQ-034 Fixed priority: FIXED_PRIORITY = 1, both requesting, outReady = 1 for 3 cycles -> ackA = 1 each cycle, ackB = 0, select = 0.
REQ-035 Drain: outValid = 1, outReady = 1, no requests -> next cycle outValid = 0, out and select unchanged.
